// File: rtl/sync_debounce.sv
// Input conditioner: synchronizes a raw asynchronous bit, then qualifies each level
// change over DEBOUNCE_CYCLES stable cycles before it reaches dout.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE_LOW  | dout = 0; qcnt counts consecutive edges where s = 1
// IDLE_HIGH | dout = 1; qcnt counts consecutive edges where s = 0
module sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] event_cnt,
    output logic             busy
);

    localparam int QW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [QW-1:0] Q_LAST = QW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE_LOW  = 1'b0,
        IDLE_HIGH = 1'b1
    } state_t;

    state_t                 state;
    logic [QW-1:0]          qcnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    // din is sampled only by the first stage of this chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign dout = (state == IDLE_HIGH);
    assign busy = (s != dout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE_LOW;
            qcnt      <= '0;
            rise      <= 1'b0;
            fall      <= 1'b0;
            event_cnt <= '0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (clr_cnt) begin
                event_cnt <= '0;
            end
            if (s == dout) begin
                qcnt <= '0;
            end else if (qcnt == Q_LAST) begin
                qcnt  <= '0;
                state <= s ? IDLE_HIGH : IDLE_LOW;
                rise  <= s;
                fall  <= !s;
                // a clear on the same edge takes priority and drops this event
                if (s && !clr_cnt) begin
                    event_cnt <= event_cnt + CNT_W'(1);
                end
            end else begin
                qcnt <= qcnt + QW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: a window-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sync_debounce;

    localparam int S = 2;
    localparam int D = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         din = 1'b0;
    logic         clr_cnt = 1'b0;
    logic         dout, rise, fall, busy;
    logic [W-1:0] event_cnt;

    int errors = 0;
    int checks = 0;

    sync_debounce #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .clr_cnt(clr_cnt),
        .dout(dout), .rise(rise), .fall(fall), .event_cnt(event_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: din history gives s; dout flips once the last D values of s
    // seen at clock edges all differ from the current dout.
    bit         din_log[$];
    bit         s_log[$];
    bit         m_dout = 1'b0, m_rise = 1'b0, m_fall = 1'b0, m_busy = 1'b0;
    bit [W-1:0] m_cnt = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_log.delete();
            s_log.delete();
            m_dout = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0; m_cnt = '0;
        end else begin
            bit s_seen, s_after, flip;
            s_seen = (din_log.size() >= S) ? din_log[din_log.size()-S] : 1'b0;
            din_log.push_back(din);
            s_log.push_back(s_seen);
            flip = (s_log.size() >= D);
            for (int k = 0; k < D; k++)
                if (flip && s_log[s_log.size()-1-k] == m_dout) flip = 1'b0;
            m_rise = flip && !m_dout;
            m_fall = flip && m_dout;
            if (flip) m_dout = !m_dout;
            if (clr_cnt) m_cnt = '0;
            else if (m_rise) m_cnt = m_cnt + 1'b1;
            s_after = (din_log.size() >= S) ? din_log[din_log.size()-S] : 1'b0;
            m_busy = (s_after != m_dout);
            while (din_log.size() > S + 2) void'(din_log.pop_front());
            while (s_log.size() > D + 2) void'(s_log.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("dout", dout, m_dout);
            chk("rise", rise, m_rise);
            chk("fall", fall, m_fall);
            chk("busy", busy, m_busy);
            chk("event_cnt", event_cnt, m_cnt);
            if (rise && fall) chk("rise_fall_exclusive", 1, 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int bc, rc, fc, ri, fi;

        // 1: reset then idle low
        step(3);
        chk("reset_dout", dout, 0);
        chk("reset_cnt", event_cnt, 0);
        rst_n = 1'b1;
        step(50);
        chk("idle_dout", dout, 0);
        chk("idle_busy", busy, 0);
        chk("idle_cnt", event_cnt, 0);

        // 2: clean rise, latency
        din = 1'b1;
        step(1);
        chk("t2_busy_e1", busy, 0);
        step(1);
        chk("t2_busy_e2", busy, 1);
        step(3);
        chk("t2_dout_e5", dout, 0);
        step(1);
        chk("t2_dout_e6", dout, 1);
        chk("t2_rise_e6", rise, 1);
        step(1);
        chk("t2_rise_e7", rise, 0);
        chk("t2_cnt", event_cnt, 1);

        // 3a: 3-cycle glitch rejected
        din = 1'b0;
        step(12);
        bc = 0; rc = 0;
        din = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) din = 1'b0;
            bc += int'(busy); rc += int'(rise);
        end
        chk("t3_glitch_busy_cycles", bc, 3);
        chk("t3_glitch_rise", rc, 0);
        chk("t3_glitch_dout", dout, 0);
        chk("t3_glitch_cnt", event_cnt, 1);

        // 3b: exactly D cycles accepted, then falls back
        rc = 0; fc = 0;
        din = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 3) din = 1'b0;
            rc += int'(rise); fc += int'(fall);
        end
        chk("t3_exact_rise", rc, 1);
        chk("t3_exact_fall", fc, 1);
        chk("t3_exact_cnt", event_cnt, 2);

        // 4: falling edge
        din = 1'b1;
        step(10);
        chk("t4_dout_high", dout, 1);
        chk("t4_cnt_pre", event_cnt, 3);
        rc = 0; fc = 0; fi = -1;
        din = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fall) begin fc++; fi = i; end
            rc += int'(rise);
        end
        chk("t4_fall_count", fc, 1);
        chk("t4_fall_edge", fi, 5);
        chk("t4_rise_count", rc, 0);
        chk("t4_cnt", event_cnt, 3);

        // 5: wrap and clear
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        chk("t5_clear_idle", event_cnt, 0);
        for (int e = 0; e < 256; e++) begin
            din = 1'b1; step(8);
            din = 1'b0; step(8);
            if (e == 254) chk("t5_cnt_255", event_cnt, 255);
        end
        chk("t5_wrap", event_cnt, 0);
        din = 1'b1;
        step(5);
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        chk("t5_clr_rise", rise, 1);
        chk("t5_clr_wins", event_cnt, 0);
        din = 1'b0; step(8);
        din = 1'b1; step(8);
        chk("t5_after_clear", event_cnt, 1);

        // 6: reset mid-qualification
        din = 1'b0;
        step(10);
        din = 1'b1;
        step(4);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dout", dout, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_cnt", event_cnt, 0);
        chk("t6_rst_rise", rise, 0);
        step(3);
        rst_n = 1'b1;
        rc = 0; ri = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rise) begin rc++; ri = i; end
        end
        chk("t6_rise_count", rc, 1);
        chk("t6_rise_edge", ri, 5);
        chk("t6_cnt", event_cnt, 1);
        chk("t6_dout", dout, 1);

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
